// File: rtl/axi2we_rb.sv
// AXI-Lite slave adapter producing single-cycle write/read strobes for a register file.
// Read-back path (re/ra/rd with RD_LATENCY) is enabled by defining AXI2WE_RB_RDBACK_EN.
module axi2we_rb #(
  parameter int unsigned     ADDR_BITS  = 8,
  parameter int unsigned     DATA_BITS  = 32,
  parameter int unsigned     RD_LATENCY = 1,
  parameter longint unsigned ADDR_LIMIT = 64'(1) << ADDR_BITS
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   s_axilite_AWVALID,
  output logic                   s_axilite_AWREADY,
  input  logic [ADDR_BITS-1:0]   s_axilite_AWADDR,
  input  logic                   s_axilite_WVALID,
  output logic                   s_axilite_WREADY,
  input  logic [DATA_BITS-1:0]   s_axilite_WDATA,
  input  logic [DATA_BITS/8-1:0] s_axilite_WSTRB,
  output logic                   s_axilite_BVALID,
  input  logic                   s_axilite_BREADY,
  output logic [1:0]             s_axilite_BRESP,
  input  logic                   s_axilite_ARVALID,
  output logic                   s_axilite_ARREADY,
  input  logic [ADDR_BITS-1:0]   s_axilite_ARADDR,
  output logic                   s_axilite_RVALID,
  input  logic                   s_axilite_RREADY,
  output logic [DATA_BITS-1:0]   s_axilite_RDATA,
  output logic [1:0]             s_axilite_RRESP,
  output logic                   we,
  output logic [ADDR_BITS-1:0]   wa,
  output logic [DATA_BITS-1:0]   wd,
  output logic [DATA_BITS/8-1:0] wm,
  output logic                   re,
  output logic [ADDR_BITS-1:0]   ra,
  input  logic [DATA_BITS-1:0]   rd
);

  localparam int unsigned STRB_BITS = DATA_BITS / 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic       {W_IDLE, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;

  function automatic logic in_range(input logic [ADDR_BITS-1:0] a);
    return 64'(a) < ADDR_LIMIT;
  endfunction

  // ---------------- write path ----------------
  w_state_e               w_state_q, w_state_d;
  logic                   aw_held_q, aw_held_d;
  logic                   w_held_q, w_held_d;
  logic [ADDR_BITS-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_BITS-1:0]   w_data_q, w_data_d;
  logic [STRB_BITS-1:0]   w_strb_q, w_strb_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   we_q, we_d;
  logic [ADDR_BITS-1:0]   wa_q, wa_d;
  logic [DATA_BITS-1:0]   wd_q, wd_d;
  logic [STRB_BITS-1:0]   wm_q, wm_d;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      wm_q      <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      we_q      <= we_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      wm_q      <= wm_d;
    end
  end

  // Hold AW and W independently; fire the strobe and response once both are present.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    we_d      = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;
    wm_d      = wm_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (s_axilite_AWVALID && awready_q) begin
          aw_held_d = 1'b1;
          aw_addr_d = s_axilite_AWADDR;
        end
        if (s_axilite_WVALID && wready_q) begin
          w_held_d = 1'b1;
          w_data_d = s_axilite_WDATA;
          w_strb_d = s_axilite_WSTRB;
        end
        if (aw_held_d && w_held_d) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = in_range(aw_addr_d) ? RESP_OKAY : RESP_SLVERR;
          we_d      = in_range(aw_addr_d);
          wa_d      = aw_addr_d;
          wd_d      = w_data_d;
          wm_d      = w_strb_d;
        end
      end
      W_RESP: begin
        if (s_axilite_BREADY) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    // Readies come out of reset low, so they first rise one cycle after release.
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  assign s_axilite_AWREADY = awready_q;
  assign s_axilite_WREADY  = wready_q;
  assign s_axilite_BVALID  = bvalid_q;
  assign s_axilite_BRESP   = bresp_q;
  assign we                = we_q;
  assign wa                = wa_q;
  assign wd                = wd_q;
  assign wm                = wm_q;

  // ---------------- read path ----------------
  r_state_e               r_state_q, r_state_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic [DATA_BITS-1:0]   rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;

`ifdef AXI2WE_RB_RDBACK_EN
  localparam int unsigned CNT_BITS = 3;
  logic                   re_q, re_d;
  logic [ADDR_BITS-1:0]   ra_q, ra_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      re_q  <= 1'b0;
      ra_q  <= '0;
      cnt_q <= '0;
    end else begin
      re_q  <= re_d;
      ra_q  <= ra_d;
      cnt_q <= cnt_d;
    end
  end

  assign re = re_q;
  assign ra = ra_q;
`else
  logic rd_unused;
  localparam int unsigned rd_latency_unused = RD_LATENCY;
  assign rd_unused = ^rd;
  assign re        = 1'b0;
  assign ra        = '0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Out-of-range reads (and all reads without read-back) answer directly next cycle.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
`ifdef AXI2WE_RB_RDBACK_EN
    re_d      = 1'b0;
    ra_d      = ra_q;
    cnt_d     = cnt_q;
`endif
    unique case (r_state_q)
      R_IDLE: begin
        if (s_axilite_ARVALID && arready_q) begin
`ifdef AXI2WE_RB_RDBACK_EN
          if (in_range(s_axilite_ARADDR)) begin
            r_state_d = R_WAIT;
            re_d      = 1'b1;
            ra_d      = s_axilite_ARADDR;
            cnt_d     = '0;
          end else begin
            r_state_d = R_RESP;
            rvalid_d  = 1'b1;
            rdata_d   = '1;
            rresp_d   = RESP_SLVERR;
          end
`else
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rdata_d   = '1;
          rresp_d   = in_range(s_axilite_ARADDR) ? RESP_OKAY : RESP_SLVERR;
`endif
        end
      end
      R_WAIT: begin
`ifdef AXI2WE_RB_RDBACK_EN
        if (cnt_q == CNT_BITS'(RD_LATENCY)) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rdata_d   = rd;
          rresp_d   = RESP_OKAY;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
`else
        r_state_d = R_IDLE;
`endif
      end
      R_RESP: begin
        if (s_axilite_RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  assign s_axilite_ARREADY = arready_q;
  assign s_axilite_RVALID  = rvalid_q;
  assign s_axilite_RDATA   = rdata_q;
  assign s_axilite_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi2we_rb.sv
// Directed bench for axi2we_rb: a 32-bit instance (limit 0x40, read latency 2) and a 64-bit instance.
module tb_axi2we_rb;

`ifdef AXI2WE_RB_RDBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // 32-bit instance
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, we, re;
  logic [7:0]  awaddr, araddr, wa, ra;
  logic [31:0] wdata, rdata, wd, rd;
  logic [3:0]  wstrb, wm;
  logic [1:0]  bresp, rresp;

  // 64-bit instance
  logic        b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready;
  logic        b_arvalid, b_arready, b_rvalid, b_rready, b_we, b_re;
  logic [7:0]  b_awaddr, b_araddr, b_wa, b_ra;
  logic [63:0] b_wdata, b_rdata, b_wd, b_rd;
  logic [7:0]  b_wstrb, b_wm;
  logic [1:0]  b_bresp, b_rresp;

  axi2we_rb #(.ADDR_BITS(8), .DATA_BITS(32), .RD_LATENCY(2), .ADDR_LIMIT(64'h40)) dut0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axilite_AWVALID(awvalid), .s_axilite_AWREADY(awready), .s_axilite_AWADDR(awaddr),
    .s_axilite_WVALID(wvalid), .s_axilite_WREADY(wready), .s_axilite_WDATA(wdata),
    .s_axilite_WSTRB(wstrb),
    .s_axilite_BVALID(bvalid), .s_axilite_BREADY(bready), .s_axilite_BRESP(bresp),
    .s_axilite_ARVALID(arvalid), .s_axilite_ARREADY(arready), .s_axilite_ARADDR(araddr),
    .s_axilite_RVALID(rvalid), .s_axilite_RREADY(rready), .s_axilite_RDATA(rdata),
    .s_axilite_RRESP(rresp),
    .we(we), .wa(wa), .wd(wd), .wm(wm), .re(re), .ra(ra), .rd(rd)
  );

  axi2we_rb #(.ADDR_BITS(8), .DATA_BITS(64)) dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axilite_AWVALID(b_awvalid), .s_axilite_AWREADY(b_awready), .s_axilite_AWADDR(b_awaddr),
    .s_axilite_WVALID(b_wvalid), .s_axilite_WREADY(b_wready), .s_axilite_WDATA(b_wdata),
    .s_axilite_WSTRB(b_wstrb),
    .s_axilite_BVALID(b_bvalid), .s_axilite_BREADY(b_bready), .s_axilite_BRESP(b_bresp),
    .s_axilite_ARVALID(b_arvalid), .s_axilite_ARREADY(b_arready), .s_axilite_ARADDR(b_araddr),
    .s_axilite_RVALID(b_rvalid), .s_axilite_RREADY(b_rready), .s_axilite_RDATA(b_rdata),
    .s_axilite_RRESP(b_rresp),
    .we(b_we), .wa(b_wa), .wd(b_wd), .wm(b_wm), .re(b_re), .ra(b_ra), .rd(b_rd)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        exp_we;
    logic [1:0]  exp_bresp;
  } wvec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] rdv;
    logic        exp_re;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } rvec_t;

  int checks = 0;
  int failures = 0;
  int we_cnt;
  wvec_t wv[6];
  rvec_t rv[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic rvec_t mk_rd(input logic [7:0] a, input logic [31:0] v);
    rvec_t r;
    r.addr = a;
    r.rdv  = v;
    if (a < 8'h40) begin
      r.exp_re    = RB;
      r.exp_lat   = RB ? 4 : 1;
      r.exp_rdata = RB ? v : 32'hFFFF_FFFF;
      r.exp_rresp = 2'b00;
    end else begin
      r.exp_re    = 1'b0;
      r.exp_lat   = 1;
      r.exp_rdata = 32'hFFFF_FFFF;
      r.exp_rresp = 2'b10;
    end
    return r;
  endfunction

  // Entered and left at posedge+1; AW and W together in cycle 0, BREADY high.
  task automatic do_write(input wvec_t v);
    awaddr = v.addr; wdata = v.data; wstrb = v.strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge ap_clk);
    check("w_ready_c0", 64'({awready, wready}), 64'(2'b11));
    @(posedge ap_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge ap_clk);
    check("w_we_c1", 64'(we), 64'(v.exp_we));
    if (v.exp_we) begin
      check("w_wa_c1", 64'(wa), 64'(v.addr));
      check("w_wd_c1", 64'(wd), 64'(v.data));
      check("w_wm_c1", 64'(wm), 64'(v.strb));
    end
    check("w_bvalid_c1", 64'(bvalid), 64'(1));
    check("w_bresp_c1", 64'(bresp), 64'(v.exp_bresp));
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    check("w_idle_c2", 64'({we, bvalid, awready, wready}), 64'(4'b0011));
    bready = 1'b0;
    @(posedge ap_clk); #1;
  endtask

  // AR in cycle 0; RREADY held low one extra cycle to test RVALID/RDATA stability.
  task automatic do_read(input rvec_t v);
    int re_cnt, re_cyc, rv_cyc;
    logic [7:0]  ra_seen;
    logic [31:0] rdata_seen;
    logic [1:0]  rresp_seen;
    re_cnt = 0; re_cyc = 0; rv_cyc = 0; ra_seen = '0;
    araddr = v.addr; rd = v.rdv; arvalid = 1'b1; rready = 1'b0;
    @(negedge ap_clk);
    check("r_arready_c0", 64'(arready), 64'(1));
    @(posedge ap_clk); #1;
    arvalid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge ap_clk);
      if (re) begin
        re_cnt++;
        if (re_cyc == 0) begin
          re_cyc  = c;
          ra_seen = ra;
        end
      end
      if (rvalid) begin
        rv_cyc = c;
        break;
      end
      @(posedge ap_clk); #1;
    end
    rdata_seen = rdata;
    rresp_seen = rresp;
    check("r_re_count", 64'(re_cnt), 64'(v.exp_re));
    check("r_re_cycle", 64'(re_cyc), 64'(v.exp_re ? 1 : 0));
    check("r_ra", 64'(ra_seen), 64'(v.exp_re ? v.addr : 8'h00));
    check("r_rvalid_cycle", 64'(rv_cyc), 64'(v.exp_lat));
    check("r_rdata", 64'(rdata_seen), 64'(v.exp_rdata));
    check("r_rresp", 64'(rresp_seen), 64'(v.exp_rresp));
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    check("r_hold", 64'({rvalid, rdata, rresp}), 64'({1'b1, v.exp_rdata, v.exp_rresp}));
    rready = 1'b1;
    @(posedge ap_clk); #1;
    rready = 1'b0;
    @(negedge ap_clk);
    check("r_done", 64'({rvalid, arready, re}), 64'(3'b010));
    @(posedge ap_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    wv[0] = '{8'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 2'b00};
    wv[1] = '{8'h3C, 32'h0102_0304, 4'h0, 1'b1, 2'b00};
    wv[2] = '{8'h3F, 32'hA5A5_5A5A, 4'h5, 1'b1, 2'b00};
    wv[3] = '{8'h40, 32'h1111_1111, 4'hF, 1'b0, 2'b10};
    wv[4] = '{8'h80, 32'h2222_2222, 4'hF, 1'b0, 2'b10};
    wv[5] = '{8'h00, 32'h7654_3210, 4'hA, 1'b1, 2'b00};
    rv[0] = mk_rd(8'h04, 32'h1234_5678);
    rv[1] = mk_rd(8'h3F, 32'hCAFE_F00D);
    rv[2] = mk_rd(8'h40, 32'h0BAD_0BAD);
    rv[3] = mk_rd(8'h80, 32'h5555_5555);
    rv[4] = mk_rd(8'h00, 32'h0000_0000);

    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; rd = '0;
    b_awvalid = 0; b_wvalid = 0; b_bready = 0; b_arvalid = 0; b_rready = 0;
    b_awaddr = '0; b_araddr = '0; b_wdata = '0; b_wstrb = '0; b_rd = '0;

    // Reset state
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_ctrl", 64'({awready, wready, arready, bvalid, rvalid, we, re}), 64'(0));
    check("rst_addr", 64'({wa, ra}), 64'(0));
    check("rst_data", 64'({wd, rdata}), 64'(0));
    check("rst_resp", 64'({wm, bresp, rresp}), 64'(0));
    check("rst_b_wd", b_wd, 64'(0));
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("rel_ready_lo", 64'({awready, wready, arready}), 64'(0));
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    check("rel_ready_hi", 64'({awready, wready, arready, b_awready}), 64'(4'b1111));
    @(posedge ap_clk); #1;

    for (int i = 0; i < 6; i++) do_write(wv[i]);
    for (int i = 0; i < 5; i++) do_read(rv[i]);

    // W in cycle 0, AW in cycle 5, BREADY low in cycles 6..8
    we_cnt = 0;
    wdata = 32'h5555_AAAA; wstrb = 4'h3; wvalid = 1'b1; bready = 1'b0;
    @(negedge ap_clk);
    check("wa_wready_c0", 64'(wready), 64'(1));
    we_cnt += int'(we);
    @(posedge ap_clk); #1;
    wvalid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge ap_clk);
      check("wa_wait", 64'({wready, awready, bvalid}), 64'(3'b010));
      we_cnt += int'(we);
      @(posedge ap_clk); #1;
    end
    awaddr = 8'h20; awvalid = 1'b1;
    @(negedge ap_clk);
    check("wa_awready_c5", 64'(awready), 64'(1));
    we_cnt += int'(we);
    @(posedge ap_clk); #1;
    awvalid = 1'b0;
    @(negedge ap_clk);
    check("wa_strobe_c6", 64'({we, wa, wd, wm}), 64'({1'b1, 8'h20, 32'h5555_AAAA, 4'h3}));
    check("wa_b_c6", 64'({bvalid, bresp}), 64'(3'b100));
    we_cnt += int'(we);
    @(posedge ap_clk); #1;
    for (int c = 7; c <= 8; c++) begin
      @(negedge ap_clk);
      check("wa_bhold", 64'({bvalid, wready, awready}), 64'(3'b100));
      we_cnt += int'(we);
      @(posedge ap_clk); #1;
    end
    bready = 1'b1;
    @(negedge ap_clk);
    check("wa_bvalid_c9", 64'({bvalid, wready}), 64'(2'b10));
    we_cnt += int'(we);
    @(posedge ap_clk); #1;
    bready = 1'b0;
    @(negedge ap_clk);
    check("wa_done_c10", 64'({bvalid, wready, awready}), 64'(3'b011));
    we_cnt += int'(we);
    check("wa_we_count", 64'(we_cnt), 64'(1));
    @(posedge ap_clk); #1;

    // Reset while BVALID pending
    awaddr = 8'h08; wdata = 32'h1111_2222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge ap_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge ap_clk);
    check("rm_we_c1", 64'({we, bvalid}), 64'(2'b11));
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    check("rm_pending_c2", 64'({we, bvalid}), 64'(2'b01));
    #1 ap_rst_n = 1'b0;
    #1;
    check("rm_async", 64'({bvalid, awready, wready, we, wa}), 64'(0));
    we_cnt = 0;
    repeat (2) begin
      @(negedge ap_clk);
      we_cnt += int'(we);
    end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    we_cnt += int'(we);
    check("rm_ready_lo", 64'(awready), 64'(0));
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    we_cnt += int'(we);
    check("rm_ready_hi", 64'({awready, wready, bvalid}), 64'(3'b110));
    check("rm_no_we", 64'(we_cnt), 64'(0));
    @(posedge ap_clk); #1;
    do_write(wv[0]);

    // 64-bit pass-through with partial strobe
    b_awaddr = 8'h33; b_wdata = 64'h0123_4567_89AB_CDEF; b_wstrb = 8'h0F;
    b_awvalid = 1'b1; b_wvalid = 1'b1; b_bready = 1'b1;
    @(negedge ap_clk);
    check("b64_ready", 64'({b_awready, b_wready}), 64'(2'b11));
    @(posedge ap_clk); #1;
    b_awvalid = 1'b0; b_wvalid = 1'b0;
    @(negedge ap_clk);
    check("b64_we", 64'({b_we, b_wa, b_wm}), 64'({1'b1, 8'h33, 8'h0F}));
    check("b64_wd", b_wd, 64'h0123_4567_89AB_CDEF);
    check("b64_b", 64'({b_bvalid, b_bresp}), 64'(3'b100));
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    check("b64_done", 64'({b_we, b_bvalid, b_awready}), 64'(3'b001));
    b_bready = 1'b0;
    @(posedge ap_clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
